// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - digit codes, scan states and segment pattern table
package seg_pkg;

    localparam logic [4:0] DASH  = 5'd16;
    localparam logic [4:0] BLANK = 5'd17;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DWELL = 1'b1
    } scan_state_t;

    // Bit order a,b,c,d,e,f,g,dp; entries 0..15 are hex glyphs, 16 is the dash.
    localparam logic [7:0] SEG_TABLE [0:16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E,
        8'h02
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - host and display signals of the segment scanner
interface seg_scan_ctrl_if;

    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic       update;
    logic [3:0] digit_en;
    logic [3:0] ctrl;
    logic [7:0] segment;
    logic       update_pending;
    logic       frame_tick;

    modport master (
        output wr_en, wr_addr, wr_data, update, digit_en,
        input  ctrl, segment, update_pending, frame_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, update, digit_en,
        output ctrl, segment, update_pending, frame_tick
    );

endinterface

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational digit code to segment pattern decoder
import seg_pkg::*;

module seg_decode (
    input  logic [4:0] code,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = 8'h00;
        if (code <= DASH) begin
            pattern = SEG_TABLE[code];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed seven-segment scanner with frame-aligned commit
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic           clk,
    input logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    scan_state_t      state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [4:0] shadow     [4];
    logic [4:0] active     [4];
    logic [4:0] active_nxt [4];

    logic       pending, pending_nxt;
    logic       commit;
    logic       tick_q, tick_nxt;
    logic [3:0] ctrl_q, ctrl_nxt;
    logic [7:0] seg_q, seg_nxt;
    logic [4:0] code_sel;
    logic [7:0] pattern;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            S_BLANK: begin
                if (!HAS_BLANK || cnt == BLANK_LAST) begin
                    state_nxt = S_DWELL;
                    cnt_nxt   = '0;
                end
            end
            S_DWELL: begin
                if (cnt == DWELL_LAST) begin
                    idx_nxt   = idx + 2'd1;
                    cnt_nxt   = '0;
                    state_nxt = HAS_BLANK ? S_BLANK : S_DWELL;
                end
            end
            default: begin
                state_nxt = S_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // tick_q is high exactly during the last dwell cycle of digit 3, so it marks the frame boundary.
    always_comb begin
        commit      = tick_q && (pending || bus.update);
        pending_nxt = commit ? 1'b0 : (pending || bus.update);
        for (int i = 0; i < 4; i++) begin
            active_nxt[i] = active[i];
            if (commit) begin
                active_nxt[i] = (bus.wr_en && bus.wr_addr == 2'(i)) ? bus.wr_data : shadow[i];
            end
        end
        code_sel = active_nxt[idx_nxt];
    end

    seg_decode u_decode (
        .code    (code_sel),
        .pattern (pattern)
    );

    // Outputs are computed from the phase being entered so they line up with the state register.
    always_comb begin
        ctrl_nxt = 4'b1111;
        seg_nxt  = 8'h00;
        if (state_nxt == S_DWELL && bus.digit_en[idx_nxt]) begin
            ctrl_nxt[idx_nxt] = 1'b0;
            seg_nxt           = pattern;
        end
        tick_nxt = (state_nxt == S_DWELL) && (idx_nxt == 2'd3) && (cnt_nxt == DWELL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_BLANK;
            idx     <= 2'd0;
            cnt     <= '0;
            pending <= 1'b0;
            tick_q  <= 1'b0;
            ctrl_q  <= 4'b1111;
            seg_q   <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= DASH;
                active[i] <= DASH;
            end
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            tick_q  <= tick_nxt;
            ctrl_q  <= ctrl_nxt;
            seg_q   <= seg_nxt;
            for (int i = 0; i < 4; i++) begin
                active[i] <= active_nxt[i];
            end
            if (bus.wr_en) begin
                shadow[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.ctrl           = ctrl_q;
    assign bus.segment        = seg_q;
    assign bus.frame_tick     = tick_q;
    assign bus.update_pending = pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic write_digit(input logic [1:0] a, input logic [4:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 5'd1; bus.update = 1'b1;
        step(); step();
        checks++; if (bus.ctrl !== 4'b1111) begin $display("FAIL reset_ctrl got=%b exp=1111", bus.ctrl); failures++; end
        checks++; if (bus.segment !== 8'h00) begin $display("FAIL reset_segment got=%h exp=00", bus.segment); failures++; end
        checks++; if (bus.frame_tick !== 1'b0) begin $display("FAIL reset_tick got=%b exp=0", bus.frame_tick); failures++; end
        checks++; if (bus.update_pending !== 1'b0) begin $display("FAIL reset_pending got=%b exp=0", bus.update_pending); failures++; end
        bus.wr_en = 1'b0; bus.update = 1'b0;
        rst = 1'b0; cyc = 0;
        step();
        checks++; if (bus.update_pending !== 1'b0) begin $display("FAIL reset_priority_pending got=%b exp=0", bus.update_pending); failures++; end
        wait_until(26);
        checks++; if (bus.segment !== 8'h02) begin $display("FAIL reset_priority_data got=%h exp=02", bus.segment); failures++; end
    endtask

    task automatic test_scan_timing();
        logic [3:0] exp_ctrl;
        logic [7:0] exp_seg;
        int first_tick;
        reset_dut();
        first_tick = -1;
        for (int k = 0; k < 48; k++) begin
            exp_ctrl = 4'b1111;
            exp_seg  = 8'h00;
            if ((k % 6) >= 2) begin
                exp_ctrl[(k / 6) % 4] = 1'b0;
                exp_seg = 8'h02;
            end
            checks++; if (bus.ctrl !== exp_ctrl || bus.segment !== exp_seg) begin
                $display("FAIL scan_cyc%0d got=%b/%h exp=%b/%h", k, bus.ctrl, bus.segment, exp_ctrl, exp_seg); failures++; end
            checks++; if (bus.frame_tick !== ((k % 24) == 23)) begin
                $display("FAIL tick_cyc%0d got=%b exp=%b", k, bus.frame_tick, (k % 24) == 23); failures++; end
            if (bus.frame_tick === 1'b1 && first_tick < 0) first_tick = k;
            step();
        end
        checks++; if (first_tick !== 23) begin $display("FAIL first_tick got=%0d exp=23", first_tick); failures++; end
    endtask

    task automatic test_update_mid_frame();
        reset_dut();
        write_digit(2'd0, 5'd1);
        write_digit(2'd1, 5'd2);
        write_digit(2'd2, 5'd3);
        write_digit(2'd3, 5'd4);
        bus.update = 1'b1; step(); bus.update = 1'b0;
        checks++; if (bus.update_pending !== 1'b1) begin $display("FAIL upd_pending_set got=%b exp=1", bus.update_pending); failures++; end
        wait_until(8);
        checks++; if (bus.segment !== 8'h02) begin $display("FAIL upd_old_d1 got=%h exp=02", bus.segment); failures++; end
        wait_until(20);
        checks++; if (bus.segment !== 8'h02) begin $display("FAIL upd_old_d3 got=%h exp=02", bus.segment); failures++; end
        wait_until(24);
        checks++; if (bus.update_pending !== 1'b0) begin $display("FAIL upd_pending_clr got=%b exp=0", bus.update_pending); failures++; end
        wait_until(26);
        checks++; if (bus.ctrl !== 4'b1110 || bus.segment !== 8'h60) begin $display("FAIL upd_d0 got=%b/%h exp=1110/60", bus.ctrl, bus.segment); failures++; end
        wait_until(32);
        checks++; if (bus.ctrl !== 4'b1101 || bus.segment !== 8'hDA) begin $display("FAIL upd_d1 got=%b/%h exp=1101/da", bus.ctrl, bus.segment); failures++; end
        wait_until(38);
        checks++; if (bus.ctrl !== 4'b1011 || bus.segment !== 8'hF2) begin $display("FAIL upd_d2 got=%b/%h exp=1011/f2", bus.ctrl, bus.segment); failures++; end
        wait_until(44);
        checks++; if (bus.ctrl !== 4'b0111 || bus.segment !== 8'h66) begin $display("FAIL upd_d3 got=%b/%h exp=0111/66", bus.ctrl, bus.segment); failures++; end
    endtask

    task automatic test_digit_en();
        reset_dut();
        bus.digit_en = 4'b0101;
        wait_until(2);
        checks++; if (bus.ctrl !== 4'b1110 || bus.segment !== 8'h02) begin $display("FAIL en_d0 got=%b/%h exp=1110/02", bus.ctrl, bus.segment); failures++; end
        wait_until(8);
        checks++; if (bus.ctrl !== 4'b1111 || bus.segment !== 8'h00) begin $display("FAIL en_d1 got=%b/%h exp=1111/00", bus.ctrl, bus.segment); failures++; end
        wait_until(14);
        checks++; if (bus.ctrl !== 4'b1011 || bus.segment !== 8'h02) begin $display("FAIL en_d2 got=%b/%h exp=1011/02", bus.ctrl, bus.segment); failures++; end
        wait_until(20);
        checks++; if (bus.ctrl !== 4'b1111 || bus.segment !== 8'h00) begin $display("FAIL en_d3 got=%b/%h exp=1111/00", bus.ctrl, bus.segment); failures++; end
        wait_until(47);
        checks++; if (bus.frame_tick !== 1'b1) begin $display("FAIL en_period got=%b exp=1", bus.frame_tick); failures++; end
        bus.digit_en = 4'hF;
    endtask

    task automatic test_tick_commit();
        reset_dut();
        wait_until(23);
        checks++; if (bus.frame_tick !== 1'b1) begin $display("FAIL tc_tick got=%b exp=1", bus.frame_tick); failures++; end
        bus.update = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 5'd8;
        step();
        bus.update = 1'b0; bus.wr_en = 1'b0;
        checks++; if (bus.update_pending !== 1'b0) begin $display("FAIL tc_pending got=%b exp=0", bus.update_pending); failures++; end
        // update right after the boundary must wait a whole frame
        bus.update = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 5'd5;
        step();
        bus.update = 1'b0; bus.wr_en = 1'b0;
        checks++; if (bus.update_pending !== 1'b1) begin $display("FAIL late_pending got=%b exp=1", bus.update_pending); failures++; end
        wait_until(26);
        checks++; if (bus.segment !== 8'h02) begin $display("FAIL late_not_yet got=%h exp=02", bus.segment); failures++; end
        wait_until(44);
        checks++; if (bus.ctrl !== 4'b0111 || bus.segment !== 8'hFE) begin $display("FAIL tc_d3 got=%b/%h exp=0111/fe", bus.ctrl, bus.segment); failures++; end
        wait_until(48);
        checks++; if (bus.update_pending !== 1'b0) begin $display("FAIL late_clr got=%b exp=0", bus.update_pending); failures++; end
        wait_until(50);
        checks++; if (bus.segment !== 8'hB6) begin $display("FAIL late_d0 got=%h exp=b6", bus.segment); failures++; end
    endtask

    task automatic test_codes();
        reset_dut();
        write_digit(2'd0, 5'd20);
        write_digit(2'd1, 5'd16);
        write_digit(2'd2, 5'd10);
        write_digit(2'd3, 5'd15);
        bus.update = 1'b1; step(); bus.update = 1'b0;
        wait_until(26);
        checks++; if (bus.ctrl !== 4'b1110 || bus.segment !== 8'h00) begin $display("FAIL code20 got=%b/%h exp=1110/00", bus.ctrl, bus.segment); failures++; end
        wait_until(32);
        checks++; if (bus.segment !== 8'h02) begin $display("FAIL code16 got=%h exp=02", bus.segment); failures++; end
        wait_until(38);
        checks++; if (bus.segment !== 8'hEE) begin $display("FAIL code10 got=%h exp=ee", bus.segment); failures++; end
        wait_until(44);
        checks++; if (bus.segment !== 8'h8E) begin $display("FAIL code15 got=%h exp=8e", bus.segment); failures++; end
    endtask

    task automatic test_reset_mid_frame();
        reset_dut();
        write_digit(2'd0, 5'd7);
        bus.update = 1'b1; step(); bus.update = 1'b0;
        wait_until(15);
        checks++; if (bus.update_pending !== 1'b1 || bus.ctrl !== 4'b1011) begin $display("FAIL rm_pre got=%b/%b exp=1/1011", bus.update_pending, bus.ctrl); failures++; end
        rst = 1'b1;
        step();
        checks++; if (bus.ctrl !== 4'b1111 || bus.segment !== 8'h00) begin $display("FAIL rm_out got=%b/%h exp=1111/00", bus.ctrl, bus.segment); failures++; end
        checks++; if (bus.update_pending !== 1'b0 || bus.frame_tick !== 1'b0) begin $display("FAIL rm_flags got=%b/%b exp=0/0", bus.update_pending, bus.frame_tick); failures++; end
        rst = 1'b0; cyc = 0;
        wait_until(2);
        checks++; if (bus.ctrl !== 4'b1110 || bus.segment !== 8'h02) begin $display("FAIL rm_restart got=%b/%h exp=1110/02", bus.ctrl, bus.segment); failures++; end
        wait_until(23);
        checks++; if (bus.frame_tick !== 1'b1) begin $display("FAIL rm_tick got=%b exp=1", bus.frame_tick); failures++; end
        wait_until(26);
        checks++; if (bus.segment !== 8'h02) begin $display("FAIL rm_d0 got=%h exp=02", bus.segment); failures++; end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 5'd0;
        bus.update = 1'b0; bus.digit_en = 4'hF;
        test_reset();
        test_scan_timing();
        test_update_mid_frame();
        test_digit_en();
        test_tick_commit();
        test_codes();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
